// File: rtl/instr_rom.sv
// Instruction memory for the processor fetch port.
// A loader streams the program in word by word; after LoadDone the block
// serves registered fetches. Addresses beyond the program return NopWord-style
// filler (NOP_WORD), and ProgEnd flags a fetch END_MARGIN words past the end.
module instr_rom #(
    parameter int          DEPTH      = 1024,
    parameter int          END_MARGIN = 10,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic                     Clock,
    input  logic                     nReset,
    input  logic                     LoadEn,
    input  logic [31:0]              LoadData,
    input  logic                     LoadDone,
    input  logic [15:0]              InstrAddr,
    output logic [31:0]              InstrMem,
    output logic [$clog2(DEPTH):0]   InstCount,
    output logic                     Running,
    output logic                     ProgEnd,
    output logic                     Overflow,
    output logic                     AddrError
);

    localparam int AddrW = $clog2(DEPTH);
    localparam int CntW  = AddrW + 1;
    localparam int IdxW  = 14;
    // Wide enough for both the 14-bit word index and InstCount+END_MARGIN
    // without wrap, so a huge fetch address can never alias onto the end mark.
    localparam int CmpW  = ((CntW + 1) > IdxW) ? (CntW + 1) : IdxW;

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        RUN
    } romStateT;

    romStateT          state;
    romStateT          nextState;

    logic [31:0]       mem [DEPTH];

    logic              canLoad;
    logic              memFull;
    logic              doWrite;
    logic              overflowSet;
    logic [AddrW-1:0]  writeIdx;
    logic [CmpW-1:0]   fetchIdx;
    logic [CmpW-1:0]   countExt;
    logic [CmpW-1:0]   endIdx;
    logic [AddrW-1:0]  memIdx;
    logic              fetchHit;
    logic [31:0]       instrNext;
    logic              addrErrSet;
    logic              progEndSet;

    // State register: EMPTY after reset, only reset leaves RUN.
    always_ff @(posedge Clock or negedge nReset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!nReset) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: LoadDone wins over LoadEn for the transition,
    // while a same-cycle write is still accepted by the datapath.
    always_comb begin
        // NOTE: defaulting before the case keeps every path assigned, so no
        // latch is inferred.
        nextState = state;
        case (state)
            EMPTY: begin
                if (LoadDone) begin
                    nextState = RUN;
                end else if (LoadEn) begin
                    nextState = LOAD;
                end
            end
            LOAD: begin
                if (LoadDone) begin
                    nextState = RUN;
                end
            end
            RUN:     nextState = RUN;
            default: nextState = EMPTY;
        endcase
    end

    // Output decode: load acceptance, fetch data selection and sticky-flag set terms.
    always_comb begin
        canLoad     = LoadEn && ((state == EMPTY) || (state == LOAD));
        memFull     = (InstCount == CntW'(DEPTH));
        doWrite     = canLoad && !memFull;
        overflowSet = canLoad && memFull;
        writeIdx    = InstCount[AddrW-1:0];

        fetchIdx    = CmpW'(InstrAddr[15:2]);
        countExt    = CmpW'(InstCount);
        endIdx      = countExt + CmpW'(END_MARGIN);
        memIdx      = fetchIdx[AddrW-1:0];
        // InstCount never exceeds DEPTH, so a hit also guarantees an in-range index.
        fetchHit    = (fetchIdx < countExt);

        instrNext   = NOP_WORD;
        if ((state == RUN) && fetchHit) begin
            instrNext = mem[memIdx];
        end

        addrErrSet  = (state == RUN) && (InstrAddr[1:0] != 2'b00);
        progEndSet  = (state == RUN) && (fetchIdx == endIdx);
    end

    // Program storage write port.
    always_ff @(posedge Clock) begin
        // NOTE: the array has no reset; with InstCount cleared its stale
        // contents can never reach InstrMem, and leaving it unreset lets it map
        // onto RAM.
        if (doWrite) begin
            mem[writeIdx] <= LoadData;
        end
    end

    // Registered outputs: fetch data, word count, run status and sticky flags.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            InstrMem  <= NOP_WORD;
            InstCount <= '0;
            Running   <= 1'b0;
            ProgEnd   <= 1'b0;
            Overflow  <= 1'b0;
            AddrError <= 1'b0;
        end else begin
            InstrMem <= instrNext;
            Running  <= (nextState == RUN);
            if (doWrite) begin
                InstCount <= InstCount + CntW'(1);
            end
            if (overflowSet) begin
                Overflow <= 1'b1;
            end
            if (addrErrSet) begin
                AddrError <= 1'b1;
            end
            if (progEndSet) begin
                ProgEnd <= 1'b1;
            end
        end
    end

endmodule
